// File: rtl/imem_loader.sv
// imem_loader: parses a length/data/XOR-checksum byte stream into instruction memory writes
// and holds the core in reset until a valid image has been loaded.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

    state_t              r_state, w_next;
    logic [15:0]         r_len;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_wcnt;
    logic [1:0]          r_idx;
    logic [31:0]         r_shift;
    logic [7:0]          r_csum;
    logic                r_we;
    logic                w_xfer, w_start, w_len_bad, w_last;
    logic [15:0]         w_len_full;

    assign w_xfer     = byte_valid && byte_ready;
    assign w_start    = load_start && (r_state == IDLE || r_state == DONE || r_state == ERR);
    assign w_len_full = {byte_data, r_len[7:0]};
    assign w_len_bad  = (w_len_full == 16'd0) || (w_len_full > 16'(DEPTH));
    // the count of finished words already includes every earlier word by the time a 4th byte lands
    assign w_last     = (16'(r_wcnt) + 16'd1) == r_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: w_next = load_start ? LEN_LO : r_state;
            LEN_LO:          w_next = w_xfer ? LEN_HI : LEN_LO;
            LEN_HI:          w_next = w_xfer ? (w_len_bad ? ERR : DATA) : LEN_HI;
            DATA:            w_next = (w_xfer && r_idx == 2'd3 && w_last) ? CSUM : DATA;
            CSUM:            w_next = w_xfer ? ((byte_data == r_csum) ? DONE : ERR) : CSUM;
            default:         w_next = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = r_state == LEN_LO || r_state == LEN_HI || r_state == DATA || r_state == CSUM;
        busy       = byte_ready;
        cpu_hold   = byte_ready || r_state == ERR;
        done       = r_state == DONE;
        error      = r_state == ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= '0;
            r_ptr   <= '0;
            r_wcnt  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_csum  <= '0;
            r_we    <= 1'b0;
        end else begin
            r_we <= w_xfer && r_state == DATA && r_idx == 2'd3;
            if (r_we) begin
                r_ptr  <= r_ptr + 1'b1;
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_start) begin
                r_ptr  <= '0;
                r_wcnt <= '0;
                r_idx  <= '0;
                r_csum <= '0;
            end else if (w_xfer) begin
                if (r_state == LEN_LO) r_len[7:0]  <= byte_data;
                if (r_state == LEN_HI) r_len[15:8] <= byte_data;
                if (r_state == DATA) begin
                    r_shift <= {byte_data, r_shift[31:8]};
                    r_csum  <= r_csum ^ byte_data;
                    r_idx   <= r_idx + 1'b1;
                end
            end
        end
    end

    assign imem_we      = r_we;
    assign imem_waddr   = r_ptr;
    assign imem_wdata   = r_shift;
    assign words_loaded = r_wcnt;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of framing, checksum, length bounds, reset abort and restart.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst, load_start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, imem_we, cpu_hold, busy, done, error;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [6:0]  words_loaded;

    int checks = 0;
    int fails  = 0;
    int base;
    logic [5:0]  wa[$];
    logic [31:0] wd[$];
    logic [7:0]  img[$]  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00, 8'hE1};
    logic [7:0]  bad[$]  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00, 8'hE0};
    logic [7:0]  big[$];
    logic [7:0]  cs;

    imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_we === 1'b1) begin
        wa.push_back(imem_waddr);
        wd.push_back(imem_wdata);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (gap) begin
            chk("gap_ready", byte_ready, 1);
            @(negedge clk);
        end
    endtask

    task automatic send_seq(input logic [7:0] s[$], input int gap);
        for (int i = 0; i < s.size(); i++) send(s[i], (i == s.size() - 1) ? 0 : gap);
    endtask

    task automatic check_good(input string t);
        chk({t, "_nwr"}, wa.size() - base, 2);
        chk({t, "_a0"}, wa[base], 0);
        chk({t, "_d0"}, wd[base], 32'h00500093);
        chk({t, "_a1"}, wa[base+1], 1);
        chk({t, "_d1"}, wd[base+1], 32'h00300113);
        chk({t, "_done"}, done, 1);
        chk({t, "_err"}, error, 0);
        chk({t, "_hold"}, cpu_hold, 0);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_wl"}, words_loaded, 2);
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_waddr, 0);
        chk("rst_data", imem_wdata, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_wl", words_loaded, 0);
        chk("rst_ready", byte_ready, 0);
        rst = 1'b0;
        @(negedge clk);

        // load_start with a byte in IDLE: the byte must not be consumed
        load_start = 1'b1; byte_valid = 1'b1; byte_data = 8'h55;
        @(negedge clk);
        load_start = 1'b0; byte_valid = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_hold", cpu_hold, 1);
        chk("start_ready", byte_ready, 1);
        base = wa.size();
        send_seq(img, 0);
        @(negedge clk);
        check_good("cont");

        // restart from DONE, then gapped stream
        pulse_start();
        chk("rs_done", done, 0);
        chk("rs_hold", cpu_hold, 1);
        chk("rs_wl", words_loaded, 0);
        base = wa.size();
        send_seq(img, 3);
        @(negedge clk);
        check_good("gap");

        pulse_start();
        base = wa.size();
        send_seq(bad, 0);
        @(negedge clk);
        chk("bad_nwr", wa.size() - base, 2);
        chk("bad_err", error, 1);
        chk("bad_done", done, 0);
        chk("bad_hold", cpu_hold, 1);
        chk("bad_ready", byte_ready, 0);

        pulse_start();
        base = wa.size();
        send(8'h00, 0); send(8'h00, 0);
        chk("len0_err", error, 1);
        chk("len0_busy", busy, 0);
        chk("len0_hold", cpu_hold, 1);
        @(negedge clk);
        chk("len0_nwr", wa.size() - base, 0);

        pulse_start();
        chk("len65_start", busy, 1);
        send(8'h41, 0); send(8'h00, 0);
        chk("len65_err", error, 1);
        chk("len65_done", done, 0);

        // maximum image: 64 words, byte k = k ^ 5A
        big = '{8'h40, 8'h00};
        cs = 8'h00;
        for (int k = 0; k < 256; k++) begin
            big.push_back(8'(k) ^ 8'h5A);
            cs ^= 8'(k) ^ 8'h5A;
        end
        big.push_back(cs);
        pulse_start();
        base = wa.size();
        send_seq(big, 0);
        @(negedge clk);
        chk("max_nwr", wa.size() - base, 64);
        chk("max_d0", wd[base], 32'h59585B5A);
        chk("max_alast", wa[base+63], 63);
        chk("max_dlast", wd[base+63], 32'hA5A4A7A6);
        chk("max_done", done, 1);
        chk("max_wl", words_loaded, 64);

        // reset during DATA after 6 data bytes
        pulse_start();
        for (int i = 0; i < 8; i++) send(img[i], 0);
        rst = 1'b1;
        #1;
        chk("mid_hold", cpu_hold, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", byte_ready, 0);
        chk("mid_wl", words_loaded, 0);
        chk("mid_we", imem_we, 0);
        chk("mid_data", imem_wdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_idle_busy", busy, 0);
        pulse_start();
        base = wa.size();
        send_seq(img, 0);
        @(negedge clk);
        check_good("after_rst");

        // load_start while in DATA is ignored
        pulse_start();
        base = wa.size();
        for (int i = 0; i < 5; i++) send(img[i], 0);
        pulse_start();
        chk("ign_busy", busy, 1);
        for (int i = 5; i < img.size(); i++) send(img[i], 0);
        @(negedge clk);
        check_good("ign");
        pulse_start();
        chk("redo_done", done, 0);
        chk("redo_hold", cpu_hold, 1);
        chk("redo_busy", busy, 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream writer that fills the CPU instruction memory write port from an external byte source (e.g. a UART receiver). It parses a framed image: a 16-bit word count, the instruction bytes, then an XOR checksum. It holds the CPU core in reset while loading and releases it only on a valid image. It is the producer side of the instruction-memory interface whose consumer is the core's instruction fetch.

Parameters:
DEPTH, 64, number of 32-bit words in instruction memory
ADDR_W, 6, word-address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  input  1  clock
rst  input  1  reset
load_start  input  1  single-cycle pulse; begins a load when in IDLE, DONE or ERR
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_waddr  output  ADDR_W  word address of the write
imem_wdata  output  32  word to write
cpu_hold  output  1  keeps the CPU core in reset while high
busy  output  1  high in LEN_LO, LEN_HI, DATA and CSUM
done  output  1  level; image loaded with a good checksum
error  output  1  level; bad length or bad checksum
words_loaded  output  ADDR_W+1  count of words written in the current load

Behaviour:
- Reset is asynchronous and active-high on rst; the clock is clk. During reset: state=IDLE, every output 0, internal length, pointer, byte index, word shift register and checksum all 0.
- A transfer occurs on a posedge where byte_valid && byte_ready. byte_ready is combinational from state: 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 elsewhere. Gaps in byte_valid of any length are legal.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE, DONE or ERR, on load_start: go to LEN_LO. Set cpu_hold=1. Clear done, error, words_loaded, checksum, byte index and pointer. load_start in any other state is ignored.
- LEN_LO, on transfer: len[7:0] <= byte. Go to LEN_HI.
- LEN_HI, on transfer: len[15:8] <= byte. If the full len == 0 or len > DEPTH, go to ERR; otherwise go to DATA.
- DATA, on transfer: bytes are packed little-endian; the first byte of each word goes to [7:0]. checksum ^= byte. The byte index counts 0 to 3.
- On the transfer that delivers byte index 3, the next cycle has imem_we=1, imem_waddr=pointer, and imem_wdata equal to the assembled word. The pointer and words_loaded increment on that same write cycle. imem_we is low in all other cycles.
- If that 4th byte completes word len-1, go to CSUM in the same cycle as the byte is accepted. The final write pulse still occurs in the first CSUM cycle.
- CSUM, on transfer: if byte == checksum, go to DONE; otherwise go to ERR.
- DONE: done=1 and cpu_hold=0. busy=0.
- ERR: error=1 and cpu_hold stays 1, so the core never runs a bad image. busy=0.
- Memory contents written before an error are left as written; there is no rollback.
- The pointer never exceeds len-1, because len is checked against DEPTH. There is no wrap-around.
- Back-to-back transfers every cycle are supported at full rate: one word per 4 cycles, with the write pulse overlapping the next word's bytes.
- rst asserted mid-load aborts immediately. All outputs go to 0, including cpu_hold, and the state returns to IDLE. A partially written memory is not cleared.
- load_start and byte_valid in the same cycle while in IDLE: only the state change happens. The byte is not accepted because byte_ready=0.

Test Plan:
- Good image, byte_valid continuous. Stream 02 00 93 00 50 00 13 01 30 00 E1 after load_start. Expect writes addr0=0x00500093 and addr1=0x00300113, one cycle each. Then done=1, cpu_hold=0, words_loaded=2, error=0.
- Same image with 3-cycle gaps between every byte. Expect identical writes and final state. byte_ready must stay 1 through the gaps, and no extra imem_we pulses may appear.
- Bad checksum: same image with a last byte of E0. Expect both words written, then error=1, done=0, cpu_hold=1, byte_ready=0.
- Length bounds, DEPTH=64. Length 00 00 -> ERR immediately after LEN_HI. Length 41 00 (65) -> ERR. Length 40 00 (64) with 256 data bytes and a correct checksum -> DONE, last write at addr 63.
- Reset mid-load: assert rst after 6 data bytes. Expect all outputs 0 at once and state IDLE. A new load_start plus a good image then completes normally.
- load_start pulsed while in DATA is ignored; the image completes. A load_start in DONE restarts the load: done clears and cpu_hold rises the next cycle.
